// File: rtl/mem_lsu_if.sv
// mem_lsu_if: core request/response handshake plus byte-enabled memory bus.
// Latency: none, wires only.
// Backpressure: req_valid/req_ready and rsp_valid/rsp_ready handshakes; mem_stall holds the bus.
// Signals: req_* core request, rsp_* core response, mem_* memory bus.
// The 'master' modport is the LSU view: it masters the memory bus and answers the core.
// The 'slave' modport is the surrounding core-plus-memory view.
interface mem_lsu_if #(
  parameter int addr_w = 32
) ();
  // core request
  logic              req_valid;
  logic              req_ready;
  logic [addr_w-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_signed;
  // core response
  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_rdata;
  logic [1:0]        rsp_err;
  // memory bus
  logic [addr_w-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_b_en;
  logic              mem_w_en;
  logic [31:0]       mem_rdata;
  logic              mem_stall;
  logic              mem_error;

  modport master (
    input  req_valid, req_addr, req_wdata, req_we, req_size, req_signed,
    input  rsp_ready,
    input  mem_rdata, mem_stall, mem_error,
    output req_ready,
    output rsp_valid, rsp_rdata, rsp_err,
    output mem_addr, mem_wdata, mem_b_en, mem_w_en
  );

  modport slave (
    output req_valid, req_addr, req_wdata, req_we, req_size, req_signed,
    output rsp_ready,
    output mem_rdata, mem_stall, mem_error,
    input  req_ready,
    input  rsp_valid, rsp_rdata, rsp_err,
    input  mem_addr, mem_wdata, mem_b_en, mem_w_en
  );
endinterface

// File: rtl/mem_lsu.sv
// mem_lsu: single-access load/store initiator for a byte-enabled single-port data memory.
// Latency: from accept, store response cycle 2, load cycle 3, misaligned cycle 1; +1 per stalled cycle.
// Backpressure: one access in flight; req_ready only in IDLE; response held until rsp_ready; mem_stall freezes the bus.
// Ports: gclk (rising edge), reset (synchronous, active-high),
//        bus (mem_lsu_if.master): req_* in / req_ready out, rsp_* out / rsp_ready in,
//        mem_addr/mem_wdata/mem_b_en/mem_w_en out, mem_rdata/mem_stall/mem_error in.
module mem_lsu #(
  parameter int addr_w      = 32,
  parameter int stall_limit = 16   // 1..255 consecutive stalled ACCESS cycles before abort
) (
  input  logic      gclk,
  input  logic      reset,
  mem_lsu_if.master bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    CAPTURE = 2'd2,
    RESP    = 2'd3
  } state_t;

  // Latched request, held for the whole transaction.
  typedef struct packed {
    logic [addr_w-1:0] addr;
    logic [31:0]       wdata;
    logic              we;
    logic [1:0]        size;
    logic              sext;
  } req_t;

  localparam logic [1:0] err_ok      = 2'b00;
  localparam logic [1:0] err_align   = 2'b01;
  localparam logic [1:0] err_bus     = 2'b10;
  localparam logic [1:0] err_timeout = 2'b11;
  localparam logic [7:0] stall_lim   = 8'(stall_limit);

  state_t      state, state_nxt;
  req_t        req_q;
  logic [7:0]  stall_cnt;
  logic [31:0] rdata_q;
  logic [1:0]  err_q;

  logic        bad_align;
  logic        stall_hit;
  logic [3:0]  lane_en;
  logic [31:0] lane_wdat;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] load_val;

  // Size 11 is illegal; half needs addr[0]=0; word needs addr[1:0]=00.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = lo[0];
      2'b10:   misaligned = (lo != 2'b00);
      default: misaligned = 1'b1;
    endcase
  endfunction

  assign bad_align = misaligned(bus.req_size, bus.req_addr[1:0]);

  // The access that would make the stall run reach the limit aborts instead.
  assign stall_hit = bus.mem_stall && (stall_cnt == stall_lim - 8'd1);

  // Lane enables and lane-replicated write data from the latched request.
  always_comb begin
    lane_en   = 4'b0000;
    lane_wdat = req_q.wdata;
    case (req_q.size)
      2'b00: begin
        lane_en   = 4'b0001 << req_q.addr[1:0];
        lane_wdat = {4{req_q.wdata[7:0]}};
      end
      2'b01: begin
        lane_en   = req_q.addr[1] ? 4'b1100 : 4'b0011;
        lane_wdat = {2{req_q.wdata[15:0]}};
      end
      2'b10: begin
        lane_en   = 4'b1111;
      end
      default: begin
        lane_en   = 4'b0000;
      end
    endcase
  end

  // Pick the addressed lane out of the returned word and extend it.
  always_comb begin
    rd_byte  = bus.mem_rdata[{req_q.addr[1:0], 3'b000} +: 8];
    rd_half  = req_q.addr[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
    load_val = bus.mem_rdata;
    case (req_q.size)
      2'b00:   load_val = {{24{req_q.sext & rd_byte[7]}}, rd_byte};
      2'b01:   load_val = {{16{req_q.sext & rd_half[15]}}, rd_half};
      default: load_val = bus.mem_rdata;
    endcase
  end

  // State register.
  always_ff @(posedge gclk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and state-decoded outputs. The memory bus is only driven in
  // ACCESS; everywhere else it is zero, so a timeout drops the enables at once.
  always_comb begin
    state_nxt     = state;
    bus.req_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.mem_b_en  = 4'b0000;
    bus.mem_w_en  = 1'b0;
    case (state)
      IDLE: begin
        bus.req_ready = !reset;
        if (bus.req_valid && !reset) begin
          state_nxt = bad_align ? RESP : ACCESS;
        end
      end
      ACCESS: begin
        bus.mem_addr  = {req_q.addr[addr_w-1:2], 2'b00};
        bus.mem_wdata = lane_wdat;
        bus.mem_b_en  = lane_en;
        bus.mem_w_en  = req_q.we;
        // Stall takes priority: mem_error is only meaningful once the stall drops.
        if (bus.mem_stall) begin
          if (stall_hit) begin
            state_nxt = RESP;
          end
        end else if (bus.mem_error || req_q.we) begin
          state_nxt = RESP;
        end else begin
          state_nxt = CAPTURE;
        end
      end
      CAPTURE: begin
        state_nxt = RESP;
      end
      RESP: begin
        bus.rsp_valid = 1'b1;
        if (bus.rsp_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Request latch, stall counter and response registers.
  always_ff @(posedge gclk) begin
    if (reset) begin
      req_q     <= '0;
      stall_cnt <= 8'd0;
      rdata_q   <= 32'd0;
      err_q     <= err_ok;
    end else begin
      // ACCESS only loops on itself while stalled; any exit clears the count.
      if (state == ACCESS && state_nxt == ACCESS) begin
        stall_cnt <= stall_cnt + 8'd1;
      end else begin
        stall_cnt <= 8'd0;
      end

      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            req_q   <= {bus.req_addr, bus.req_wdata, bus.req_we, bus.req_size, bus.req_signed};
            // Cleared here so stores and failed accesses report zero data.
            rdata_q <= 32'd0;
            err_q   <= bad_align ? err_align : err_ok;
          end
        end
        ACCESS: begin
          if (bus.mem_stall) begin
            if (stall_hit) begin
              err_q <= err_timeout;
            end
          end else if (bus.mem_error) begin
            err_q <= err_bus;
          end
        end
        CAPTURE: begin
          rdata_q <= load_val;
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;

endmodule

// File: tb/tb_mem_lsu.sv
// tb_mem_lsu: directed table, hand-written corner sequences and random traffic for mem_lsu.
// A 64-byte memory device answers the bus; addresses 64 and above raise mem_error.
// Expected results come from a byte-array reference model of loads and stores.
module tb_mem_lsu;

  logic gclk = 1'b0;
  always #5 gclk = ~gclk;

  logic reset;
  logic mem_clr;

  mem_lsu_if #(.addr_w(32)) bus ();

  mem_lsu #(.addr_w(32), .stall_limit(16)) dut (
    .gclk  (gclk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // ---------------- memory device (bus level) ----------------
  logic [31:0] dev_mem [16];

  assign bus.mem_error = (bus.mem_b_en != 4'b0000) && (bus.mem_addr >= 32'd64);

  always @(posedge gclk) begin
    if (mem_clr) begin
      for (int i = 0; i < 16; i++) dev_mem[i] <= 32'd0;
    end else if (bus.mem_b_en != 4'b0000 && !bus.mem_stall && !bus.mem_error) begin
      for (int i = 0; i < 4; i++)
        if (bus.mem_w_en && bus.mem_b_en[i])
          dev_mem[bus.mem_addr[5:2]][8*i +: 8] <= bus.mem_wdata[8*i +: 8];
      bus.mem_rdata <= dev_mem[bus.mem_addr[5:2]];
    end
  end

  // ---------------- reference model (transaction level) ----------------
  logic [7:0] ref_mem [64];

  function automatic void ref_model(input logic we, input logic [1:0] size, input logic sgn,
                                    input logic [31:0] addr, input logic [31:0] wdata,
                                    output logic [31:0] rd, output logic [1:0] err,
                                    output logic [3:0] ben);
    int n;
    int a;
    logic [31:0] v;
    rd  = 32'd0;
    ben = 4'b0000;
    a   = int'(addr);
    n   = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
    if (size == 2'b11 || (a % n) != 0) begin
      err = 2'b01;
      return;
    end
    for (int k = 0; k < n; k++) ben[(a + k) % 4] = 1'b1;
    if (a >= 64) begin
      err = 2'b10;
      return;
    end
    err = 2'b00;
    if (we) begin
      for (int k = 0; k < n; k++) ref_mem[a + k] = wdata[8*k +: 8];
    end else begin
      v = 32'd0;
      for (int k = 0; k < n; k++) v[8*k +: 8] = ref_mem[a + k];
      if (sgn && v[8*n-1]) for (int b = 8*n; b < 32; b++) v[b] = 1'b1;
      rd = v;
    end
  endfunction

  // ---------------- transaction driver ----------------
  typedef struct {
    logic [31:0] rdata;
    logic [1:0]  err;
    int          lat;
    logic [3:0]  ben;
    logic [31:0] wdat;
    logic        wen;
    logic        held;
    logic [3:0]  ben_rsp;
  } obs_t;

  // Stall is held high for cycles 1..stall_n after the accept edge; the
  // response is held for hold_n cycles before rsp_ready is raised.
  task automatic xact(input logic we, input logic [1:0] size, input logic sgn,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      input int stall_n, input int hold_n, output obs_t o);
    int cyc;
    logic [31:0] a0;
    logic [3:0]  b0;
    o.rdata = '0; o.err = '0; o.lat = -1; o.ben = '0; o.wdat = '0;
    o.wen = 1'b0; o.held = 1'b1; o.ben_rsp = '0;
    a0 = '0; b0 = '0;
    @(negedge gclk);
    for (int w = 0; w < 50 && !bus.req_ready; w++) @(negedge gclk);
    chk("req_ready_wait", 32'(bus.req_ready), 32'd1);
    bus.req_valid  = 1'b1;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    bus.req_we     = we;
    bus.req_size   = size;
    bus.req_signed = sgn;
    @(posedge gclk);
    #1;
    bus.req_valid = 1'b0;
    bus.mem_stall = (stall_n >= 1);
    for (cyc = 1; cyc <= 40; cyc++) begin
      @(negedge gclk);
      if (bus.mem_b_en != 4'b0000) begin
        if (o.ben == 4'b0000) begin
          a0 = bus.mem_addr; b0 = bus.mem_b_en; o.wdat = bus.mem_wdata;
        end else if (bus.mem_addr != a0 || bus.mem_b_en != b0 || bus.mem_wdata != o.wdat) begin
          o.held = 1'b0;
        end
        o.ben = o.ben | bus.mem_b_en;
      end
      o.wen = o.wen | bus.mem_w_en;
      if (bus.rsp_valid) break;
      @(posedge gclk);
      #1;
      bus.mem_stall = ((cyc + 1) <= stall_n);
    end
    bus.mem_stall = 1'b0;
    chk("rsp_valid_seen", 32'(bus.rsp_valid), 32'd1);
    o.lat     = cyc;
    o.rdata   = bus.rsp_rdata;
    o.err     = bus.rsp_err;
    o.ben_rsp = bus.mem_b_en;
    for (int i = 0; i < hold_n; i++) begin
      @(negedge gclk);
      if (!bus.rsp_valid || bus.rsp_rdata != o.rdata || bus.rsp_err != o.err ||
          bus.req_ready || bus.mem_b_en != 4'b0000) o.held = 1'b0;
    end
    bus.rsp_ready = 1'b1;
    @(posedge gclk);
    #1;
    bus.rsp_ready = 1'b0;
    @(negedge gclk);
    chk("ready_after_rsp", {30'd0, bus.req_ready, bus.rsp_valid}, 32'd2);
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] e_rdata;
    logic [1:0]  e_err;
    int          e_lat;
    logic [3:0]  e_ben;
    logic [31:0] e_wdat;
  } vec_t;

  vec_t vt [18];

  initial begin
    obs_t        o;
    logic [31:0] erd;
    logic [1:0]  eerr;
    logic [3:0]  eben;
    logic        we, sgn;
    logic [1:0]  size;
    logic [31:0] addr, wdata;
    int          stall_n, elat;

    //          we    size   sgn   addr      wdata          rdata          err    lat ben      wdat
    vt[0]  = '{1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 32'h00000000, 2'b00, 2, 4'b1111, 32'hDEADBEEF};
    vt[1]  = '{1'b0, 2'b10, 1'b0, 32'h10, 32'h00000000, 32'hDEADBEEF, 2'b00, 3, 4'b1111, 32'h00000000};
    vt[2]  = '{1'b1, 2'b00, 1'b0, 32'h13, 32'h000000A5, 32'h00000000, 2'b00, 2, 4'b1000, 32'hA5A5A5A5};
    vt[3]  = '{1'b0, 2'b00, 1'b1, 32'h13, 32'h00000000, 32'hFFFFFFA5, 2'b00, 3, 4'b1000, 32'h00000000};
    vt[4]  = '{1'b0, 2'b00, 1'b0, 32'h13, 32'h00000000, 32'h000000A5, 2'b00, 3, 4'b1000, 32'h00000000};
    vt[5]  = '{1'b0, 2'b01, 1'b1, 32'h12, 32'h00000000, 32'hFFFFA5AD, 2'b00, 3, 4'b1100, 32'h00000000};
    vt[6]  = '{1'b0, 2'b01, 1'b0, 32'h12, 32'h00000000, 32'h0000A5AD, 2'b00, 3, 4'b1100, 32'h00000000};
    vt[7]  = '{1'b0, 2'b01, 1'b1, 32'h11, 32'h00000000, 32'h00000000, 2'b01, 1, 4'b0000, 32'h00000000};
    vt[8]  = '{1'b0, 2'b10, 1'b0, 32'h12, 32'h00000000, 32'h00000000, 2'b01, 1, 4'b0000, 32'h00000000};
    vt[9]  = '{1'b1, 2'b11, 1'b0, 32'h10, 32'h12345678, 32'h00000000, 2'b01, 1, 4'b0000, 32'h00000000};
    vt[10] = '{1'b0, 2'b10, 1'b0, 32'h10, 32'h00000000, 32'hA5ADBEEF, 2'b00, 3, 4'b1111, 32'h00000000};
    vt[11] = '{1'b1, 2'b01, 1'b0, 32'h16, 32'h1234BEEF, 32'h00000000, 2'b00, 2, 4'b1100, 32'hBEEFBEEF};
    vt[12] = '{1'b0, 2'b10, 1'b0, 32'h14, 32'h00000000, 32'hBEEF0000, 2'b00, 3, 4'b1111, 32'h00000000};
    vt[13] = '{1'b0, 2'b00, 1'b1, 32'h16, 32'h00000000, 32'hFFFFFFEF, 2'b00, 3, 4'b0100, 32'h00000000};
    vt[14] = '{1'b1, 2'b10, 1'b0, 32'h40, 32'h11111111, 32'h00000000, 2'b10, 2, 4'b1111, 32'h11111111};
    vt[15] = '{1'b0, 2'b10, 1'b0, 32'h44, 32'h00000000, 32'h00000000, 2'b10, 2, 4'b1111, 32'h00000000};
    vt[16] = '{1'b1, 2'b00, 1'b0, 32'h18, 32'h0000007F, 32'h00000000, 2'b00, 2, 4'b0001, 32'h7F7F7F7F};
    vt[17] = '{1'b0, 2'b00, 1'b1, 32'h18, 32'h00000000, 32'h0000007F, 2'b00, 3, 4'b0001, 32'h00000000};

    for (int i = 0; i < 64; i++) ref_mem[i] = 8'h00;
    bus.req_valid = 1'b0; bus.req_addr = '0; bus.req_wdata = '0; bus.req_we = 1'b0;
    bus.req_size = 2'b00; bus.req_signed = 1'b0; bus.rsp_ready = 1'b0; bus.mem_stall = 1'b0;
    mem_clr = 1'b1;
    reset   = 1'b1;
    repeat (3) @(posedge gclk);
    @(negedge gclk);
    chk("reset_req_ready_low", 32'(bus.req_ready), 32'd0);
    mem_clr = 1'b0;
    reset   = 1'b0;
    @(negedge gclk);
    chk("reset_req_ready", 32'(bus.req_ready), 32'd1);
    chk("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("reset_mem_b_en", 32'(bus.mem_b_en), 32'd0);
    chk("reset_mem_w_en", 32'(bus.mem_w_en), 32'd0);
    chk("reset_mem_addr", bus.mem_addr, 32'd0);
    chk("reset_rsp_err", 32'(bus.rsp_err), 32'd0);
    chk("reset_rsp_rdata", bus.rsp_rdata, 32'd0);

    // ---- directed table ----
    for (int i = 0; i < 18; i++) begin
      xact(vt[i].we, vt[i].size, vt[i].sgn, vt[i].addr, vt[i].wdata, 0, 0, o);
      ref_model(vt[i].we, vt[i].size, vt[i].sgn, vt[i].addr, vt[i].wdata, erd, eerr, eben);
      chk($sformatf("vec%0d_rdata", i), o.rdata, vt[i].e_rdata);
      chk($sformatf("vec%0d_err", i), 32'(o.err), 32'(vt[i].e_err));
      chk($sformatf("vec%0d_lat", i), 32'(o.lat), 32'(vt[i].e_lat));
      chk($sformatf("vec%0d_ben", i), 32'(o.ben), 32'(vt[i].e_ben));
      chk($sformatf("vec%0d_wdat", i), o.wdat, vt[i].e_wdat);
      chk($sformatf("vec%0d_wen", i), 32'(o.wen), 32'(vt[i].we && vt[i].e_err != 2'b01));
    end

    // ---- stall 3 cycles on a load, then on a store ----
    xact(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 3, 0, o);
    chk("stall3_load_lat", 32'(o.lat), 32'd6);
    chk("stall3_load_rdata", o.rdata, 32'hA5ADBEEF);
    chk("stall3_load_held", 32'(o.held), 32'd1);
    xact(1'b1, 2'b10, 1'b0, 32'h20, 32'hCAFEF00D, 3, 0, o);
    ref_model(1'b1, 2'b10, 1'b0, 32'h20, 32'hCAFEF00D, erd, eerr, eben);
    chk("stall3_store_lat", 32'(o.lat), 32'd5);
    chk("stall3_store_held", 32'(o.held), 32'd1);

    // ---- stall run reaching the limit aborts; one short of it completes ----
    xact(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 16, 0, o);
    chk("timeout_err", 32'(o.err), 32'd3);
    chk("timeout_lat", 32'(o.lat), 32'd17);
    chk("timeout_rdata", o.rdata, 32'd0);
    chk("timeout_ben_dropped", 32'(o.ben_rsp), 32'd0);
    xact(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 15, 0, o);
    chk("stall15_err", 32'(o.err), 32'd0);
    chk("stall15_lat", 32'(o.lat), 32'd18);
    chk("stall15_rdata", o.rdata, 32'hCAFEF00D);

    // ---- bus error with response held 5 cycles ----
    xact(1'b0, 2'b10, 1'b0, 32'h44, 32'h0, 0, 5, o);
    chk("buserr_err", 32'(o.err), 32'd2);
    chk("buserr_rdata", o.rdata, 32'd0);
    chk("buserr_hold_stable", 32'(o.held), 32'd1);

    // ---- reset while in CAPTURE ----
    @(negedge gclk);
    bus.req_valid = 1'b1; bus.req_addr = 32'h10; bus.req_we = 1'b0;
    bus.req_size = 2'b10; bus.req_signed = 1'b0; bus.req_wdata = '0;
    @(posedge gclk);
    #1 bus.req_valid = 1'b0;
    @(negedge gclk);
    chk("rstcap_access_ben", 32'(bus.mem_b_en), 32'hF);
    @(negedge gclk);
    chk("rstcap_capture_ben", 32'(bus.mem_b_en), 32'd0);
    reset = 1'b1;
    @(negedge gclk);
    chk("rstcap_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rstcap_ready_in_reset", 32'(bus.req_ready), 32'd0);
    reset = 1'b0;
    @(negedge gclk);
    chk("rstcap_ready_after", 32'(bus.req_ready), 32'd1);
    chk("rstcap_rsp_valid_after", 32'(bus.rsp_valid), 32'd0);

    // ---- randomized traffic against the reference model ----
    for (int t = 0; t < 300; t++) begin
      we    = 1'($urandom_range(0, 1));
      sgn   = 1'($urandom_range(0, 1));
      size  = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      addr  = 32'($urandom_range(0, 79));
      if ($urandom_range(0, 3) != 0 && size != 2'b11)
        addr = (size == 2'b10) ? (addr & ~32'd3) : (size == 2'b01) ? (addr & ~32'd1) : addr;
      wdata   = $urandom;
      stall_n = ($urandom_range(0, 9) < 7) ? 0 : int'($urandom_range(1, 3));
      ref_model(we, size, sgn, addr, wdata, erd, eerr, eben);
      elat = (eerr == 2'b01) ? 1 : (we || eerr == 2'b10) ? 2 + stall_n : 3 + stall_n;
      xact(we, size, sgn, addr, wdata, stall_n, int'($urandom_range(0, 2)), o);
      chk($sformatf("rnd%0d_err", t), 32'(o.err), 32'(eerr));
      chk($sformatf("rnd%0d_rdata", t), o.rdata, erd);
      chk($sformatf("rnd%0d_lat", t), 32'(o.lat), 32'(elat));
      chk($sformatf("rnd%0d_ben", t), 32'(o.ben), 32'(eben));
      chk($sformatf("rnd%0d_held", t), 32'(o.held), 32'd1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_lsu.md
# mem_lsu

Load/store initiator driving the core's byte-enabled single-port memory bus: takes one byte/half/word access from the core pipeline, drives word address, lane enables, aligned write data and write enable onto the memory, and returns a sign- or zero-extended load result. It honours memory `stall`, samples memory `error`, rejects misaligned accesses without touching the bus, and aborts accesses stalled past a limit. It sits between the multi-cycle core's execute/memory stage and the data memory.

## Interface
- `addr_w`, 32, memory address width; `req_addr` and `mem_addr` width.
- `stall_limit`, 16, max consecutive stalled ACCESS cycles before abort (1..255).
- `gclk` in 1 global clock; all logic on rising edge.
- `reset` in 1 synchronous, active-high reset.
- `req_valid` in 1 core request valid.
- `req_ready` out 1 high only in IDLE with `reset` low.
- `req_addr` in addr_w byte address.
- `req_wdata` in 32 store data, right-justified.
- `req_we` in 1 1 = store, 0 = load.
- `req_size` in 2 00 byte, 01 half, 10 word, 11 illegal.
- `req_signed` in 1 loads: 1 sign-extend, 0 zero-extend.
- `rsp_valid` out 1 response valid; held until accepted.
- `rsp_ready` in 1 core accepts response.
- `rsp_rdata` out 32 load result; 0 for stores and errors.
- `rsp_err` out 2 00 ok, 01 misaligned/illegal size, 10 bus error, 11 stall timeout.
- `mem_addr` out addr_w `{req_addr[addr_w-1:2],2'b00}`.
- `mem_wdata` out 32 lane-replicated store data.
- `mem_b_en` out 4 byte lane enables.
- `mem_w_en` out 1 write enable.
- `mem_rdata` in 32 registered read data; valid cycle after enabled access.
- `mem_stall` in 1 memory not ready; hold access.
- `mem_error` in 1 memory out-of-range, sampled in the non-stalled ACCESS cycle.

## Operation
- States: IDLE, ACCESS, CAPTURE, RESP. Reset: state IDLE; all registered outputs 0; `mem_b_en`=0, `mem_w_en`=0; stall counter 0.
- IDLE: on `req_valid & req_ready`, latch addr/wdata/we/size/signed. Misaligned (half with addr[0]=1, word with addr[1:0]!=0) or size 11: go RESP, `rsp_err`=01, no bus cycle. Otherwise go ACCESS.
- Lanes: byte `mem_b_en`=1<<addr[1:0], `mem_wdata`={4{wdata[7:0]}}; half addr[1]?1100:0011, `mem_wdata`={2{wdata[15:0]}}; word 1111, wdata as-is.
- ACCESS: drive `mem_addr`, `mem_b_en`, `mem_wdata`, `mem_w_en`=`we`. If `mem_stall`: hold all outputs, increment counter; counter reaching `stall_limit` -> RESP, `rsp_err`=11, enables deasserted. Not stalled: `mem_error`=1 -> RESP, `rsp_err`=10; store -> RESP, err 00; load -> CAPTURE.
- CAPTURE: `mem_b_en`=0, `mem_w_en`=0; extract lane from `mem_rdata` by addr[1:0]/size, extend per `req_signed`, register into `rsp_rdata`; go RESP, err 00.
- RESP: `rsp_valid`=1, outputs stable until `rsp_ready`; then IDLE, `rsp_valid` drops next cycle. Counter cleared on leaving ACCESS.
- Memory outputs zero in IDLE, CAPTURE, RESP.

## Timing
- Accept edge = cycle 0. Store: ACCESS cycle 1, memory writes at end of cycle 1, `rsp_valid` cycle 2. Load: ACCESS 1, CAPTURE 2, `rsp_valid` 3. Each stalled cycle adds 1. Misaligned: `rsp_valid` cycle 1.
- `rsp_ready` high in first RESP cycle: `req_ready` high next cycle; max throughput one store per 3 cycles, one load per 4.
- `req_ready` is combinational from state; `req_valid` while not ready is ignored, not queued.
- `reset` high in any state: next edge IDLE, pending access dropped, no response; a write already presented in ACCESS that cycle may complete in memory.
- `mem_stall` and `mem_error` both high: stall wins; error ignored until stall drops.

## Test plan
- SW addr 0x10, data 0xDEADBEEF, then LW 0x10 -> `mem_b_en`=1111 in cycle 1; load `rsp_rdata`=0xDEADBEEF, `rsp_valid` at cycle 3, err 00.
- SB 0x13 data 0x000000A5 -> `mem_b_en`=1000, `mem_wdata`=0xA5A5A5A5; LB signed 0x13 -> 0xFFFFFFA5; LBU -> 0x000000A5; LH 0x12 -> 0xFFFFA5xx per stored lanes.
- LH 0x11 and LW 0x12 and size 11 -> `rsp_err`=01 at cycle 1, `mem_b_en` never nonzero.
- `mem_stall` high 3 cycles during LW -> address/enables held, response at cycle 6; stall held 16 cycles with `stall_limit`=16 -> `rsp_err`=11, enables drop.
- `mem_error` high in ACCESS of LW -> `rsp_err`=10, `rsp_rdata`=0; `rsp_ready` low 5 cycles -> response held stable, `req_ready` low.
- `reset` asserted in CAPTURE -> next cycle IDLE, `rsp_valid`=0, `req_ready`=1 after reset drops.
